cas_recorder: RTL

Cassette recording path for the CoCo3 core, the write-side counterpart of the tape player. While the cassette relay is closed it watches the 6-bit sound DAC, decodes the CoCo FSK signal into bits (1200 Hz = 0, 2400 Hz = 1, LSB first) and packs them into bytes. Each byte is written sequentially into the 64 KB tape SRAM, so the captured stream is a .CAS image that the HPS can upload or the player can replay.

---
 rtl/cas_recorder_pkg.sv | 29 ++
 rtl/cas_recorder_if.sv | 9 +
 rtl/cas_recorder_meter.sv | 63 ++++++
 rtl/cas_recorder.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/cas_recorder_pkg.sv
// rtl/cas_recorder_pkg.sv - shared cassette types and FSK period limits (recorder and player)
package cas_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2,
        ST_FULL = 2'd3
    } cas_state_e;

    localparam int FSK_ZERO_HZ = 1200;
    localparam int FSK_ONE_HZ  = 2400;

    // Shortest credible period: 1.5x the "1" tone frequency
    function automatic int min_cyc(input int clk_hz);
        return clk_hz / (FSK_ONE_HZ * 3 / 2);
    endfunction

    // Boundary between the two tones, geometric-ish midpoint
    function automatic int split_cyc(input int clk_hz);
        return clk_hz / (FSK_ZERO_HZ * 4 / 3);
    endfunction

    // Anything slower than 2/3 of the "0" tone is a gap
    function automatic int max_cyc(input int clk_hz);
        return clk_hz / (FSK_ZERO_HZ * 2 / 3);
    endfunction

endpackage

// File: rtl/cas_recorder_if.sv
// rtl/cas_recorder_if.sv - tape SRAM write port
interface cas_recorder_if;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_en;

    modport master (output wr_addr, output wr_data, output wr_en);
    modport slave  (input  wr_addr, input  wr_data, input  wr_en);
endinterface

// File: rtl/cas_recorder_meter.sv
// rtl/cas_recorder_meter.sv - Schmitt comparator, rising-edge detect and period classifier
module fsk_period_meter #(
    parameter logic [5:0]  HI_LVL  = 6'd40,
    parameter logic [5:0]  LO_LVL  = 6'd24,
    parameter logic [16:0] MIN_L   = 17'd13888,
    parameter logic [16:0] SPLIT_L = 17'd31250,
    parameter logic [16:0] MAX_L   = 17'd62500
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       run_i,
    input  logic [5:0] dac_i,
    output logic       rise_o,
    output logic       bit_valid_o,
    output logic       bit_val_o,
    output logic       gap_o,
    output logic       timeout_o
);

    logic        lvl_q, lvl_d;
    logic        lvl_prev_q;
    logic [16:0] cnt_q, cnt_d;
    logic        rise, accept;

    always_comb begin
        lvl_d = lvl_q;
        if (dac_i >= HI_LVL)
            lvl_d = 1'b1;
        else if (dac_i <= LO_LVL)
            lvl_d = 1'b0;
    end

    assign rise   = lvl_q & ~lvl_prev_q;
    // Outside RUN every edge is a fresh reference; inside RUN short ones are glitches
    assign accept = rise & (~run_i | (cnt_q >= MIN_L));

    always_comb begin
        cnt_d = cnt_q;
        if (accept)
            cnt_d = 17'd0;
        else if (cnt_q != '1)
            cnt_d = cnt_q + 17'd1;
    end

    assign rise_o      = accept & ~run_i;
    assign bit_valid_o = run_i & rise & (cnt_q >= MIN_L) & (cnt_q <= MAX_L);
    assign bit_val_o   = (cnt_q <= SPLIT_L);
    assign gap_o       = run_i & rise & (cnt_q > MAX_L);
    assign timeout_o   = run_i & ~rise & (cnt_q > MAX_L);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lvl_q      <= 1'b0;
            lvl_prev_q <= 1'b0;
            cnt_q      <= 17'd0;
        end else begin
            lvl_q      <= lvl_d;
            lvl_prev_q <= lvl_q;
            cnt_q      <= cnt_d;
        end
    end

endmodule

// File: rtl/cas_recorder.sv
// rtl/cas_recorder.sv - FSK cassette capture into tape SRAM as a .CAS byte stream
module cas_recorder
    import cas_pkg::*;
#(
    parameter int         CLK_HZ    = 50_000_000,
    parameter logic [5:0] HI_LVL    = 6'd40,
    parameter logic [5:0] LO_LVL    = 6'd24,
    parameter int         MIN_CYC   = min_cyc(CLK_HZ),
    parameter int         SPLIT_CYC = split_cyc(CLK_HZ),
    parameter int         MAX_CYC   = max_cyc(CLK_HZ)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  en,
    input  logic                  clear,
    input  logic [5:0]            dac,
    cas_recorder_if.master        wr,
    output logic [16:0]           length,
    output logic                  full,
    output logic                  busy
);

    localparam logic [16:0] MIN_L   = 17'(MIN_CYC);
    localparam logic [16:0] SPLIT_L = 17'(SPLIT_CYC);
    localparam logic [16:0] MAX_L   = 17'(MAX_CYC);

    cas_state_e  state_q, state_d;
    logic [6:0]  sh_q, sh_d;
    logic [2:0]  bc_q, bc_d;
    logic [15:0] addr_q, addr_d;
    logic [16:0] len_q, len_d;
    logic        full_q, full_d;
    logic        wr_en_q, wr_en_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic [7:0]  byte_nxt;

    logic rise, bit_valid, bit_val, gap, timeout;

    fsk_period_meter #(
        .HI_LVL  (HI_LVL),
        .LO_LVL  (LO_LVL),
        .MIN_L   (MIN_L),
        .SPLIT_L (SPLIT_L),
        .MAX_L   (MAX_L)
    ) u_meter (
        .clk         (clk),
        .reset_n     (reset_n),
        .run_i       (state_q == ST_RUN),
        .dac_i       (dac),
        .rise_o      (rise),
        .bit_valid_o (bit_valid),
        .bit_val_o   (bit_val),
        .gap_o       (gap),
        .timeout_o   (timeout)
    );

    always_comb begin
        state_d   = state_q;
        sh_d      = sh_q;
        bc_d      = bc_q;
        addr_d    = addr_q;
        len_d     = len_q;
        full_d    = full_q;
        wr_en_d   = 1'b0;
        wr_data_d = wr_data_q;
        byte_nxt  = {bit_val, sh_q};

        // Address advances the cycle after the strobe so it is stable during the write
        if (wr_en_q)
            addr_d = addr_q + 16'd1;

        case (state_q)
            ST_IDLE: begin
                if (en && !full_q)
                    state_d = ST_ARM;
            end
            ST_ARM: begin
                if (!en) begin
                    state_d = ST_IDLE;
                end else if (rise) begin
                    state_d = ST_RUN;
                    sh_d    = 7'd0;
                    bc_d    = 3'd0;
                end
            end
            ST_RUN: begin
                if (!en || timeout) begin
                    state_d = en ? ST_ARM : ST_IDLE;
                    sh_d    = 7'd0;
                    bc_d    = 3'd0;
                end else if (gap) begin
                    sh_d = 7'd0;
                    bc_d = 3'd0;
                end else if (bit_valid) begin
                    if (bc_q == 3'd7) begin
                        wr_en_d   = 1'b1;
                        wr_data_d = byte_nxt;
                        len_d     = len_q + 17'd1;
                        bc_d      = 3'd0;
                        if (addr_q == 16'hFFFF) begin
                            full_d  = 1'b1;
                            state_d = ST_FULL;
                        end
                    end else begin
                        sh_d = byte_nxt[7:1];
                        bc_d = bc_q + 3'd1;
                    end
                end
            end
            ST_FULL: ;
            default: state_d = ST_IDLE;
        endcase

        // Rewind wins over everything, including a byte completing this cycle
        if (clear) begin
            addr_d  = 16'd0;
            len_d   = 17'd0;
            full_d  = 1'b0;
            sh_d    = 7'd0;
            bc_d    = 3'd0;
            wr_en_d = 1'b0;
            state_d = en ? ST_ARM : ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            sh_q      <= 7'd0;
            bc_q      <= 3'd0;
            addr_q    <= 16'd0;
            len_q     <= 17'd0;
            full_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_data_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            sh_q      <= sh_d;
            bc_q      <= bc_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            full_q    <= full_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign wr.wr_addr = addr_q;
    assign wr.wr_data = wr_data_q;
    assign wr.wr_en   = wr_en_q;
    assign length     = len_q;
    assign full       = full_q;
    assign busy       = (state_q == ST_ARM) || (state_q == ST_RUN);

endmodule
